uart_rx_word: RTL

UART receiver that assembles PC-side serial bytes into 32-bit words for the CAN controller's transmit interface. It is the inbound counterpart of the CAN-RX-to-UART-TX path: bytes arrive on the FPGA's UART RX pad, are grouped four at a time, and are presented on a valid/ready handshake that drives the CAN controller's `tx_valid`/`tx_ready`/`tx_data` directly.

---
 rtl/uart_rx_pkg.sv | 14 +
 rtl/uart_rx_byte.sv | 109 ++++++++++
 rtl/uart_rx_word.sv | 104 ++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types and constants for the UART word receiver
package uart_rx_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 byte receiver: pad synchronizer plus bit-level FSM
module uart_rx_byte
    import uart_rx_pkg::*;
#(
    parameter int CLK_DIV = 434
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      rx_i,
    output logic                      byte_valid_o,
    output logic [UART_DATA_BITS-1:0] byte_data_o,
    output logic                      frame_err_o,
    output logic                      idle_o
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int IDX_W = $clog2(UART_DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(UART_DATA_BITS - 1);

    uart_rx_state_t            state_q;
    logic [1:0]                sync_q;
    logic                      rx_prev_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [IDX_W-1:0]          bit_idx_q;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic                      byte_valid_q;
    logic                      frame_err_q;
    logic                      rx_s;

    assign rx_s = sync_q[1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            sync_q       <= 2'b11;
            rx_prev_q    <= 1'b1;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], rx_i};
            rx_prev_q    <= rx_s;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rx_prev_q && !rx_s) begin
                        cnt_q   <= '0;
                        state_q <= START;
                    end
                end
                // Mid-start-bit check rejects short low glitches.
                START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        state_q   <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt_q == FULL_LAST) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s, shift_q[UART_DATA_BITS-1:1]};
                        if (bit_idx_q == LAST_BIT) begin
                            state_q <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cnt_q == FULL_LAST) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            byte_valid_q <= 1'b1;
                            state_q      <= IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= WAIT_HIGH;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // shift_q is untouched between the stop sample and the next data bit.
    assign byte_valid_o = byte_valid_q;
    assign byte_data_o  = shift_q;
    assign frame_err_o  = frame_err_q;
    assign idle_o       = (state_q == IDLE);

endmodule

// File: rtl/uart_rx_word.sv
// rtl/uart_rx_word.sv - packs received UART bytes into 32-bit words behind a valid/ready output
module uart_rx_word
    import uart_rx_pkg::*;
#(
    parameter int    CLK_DIV      = 434,
    parameter string ENDIAN       = "LITTLE",
    parameter int    TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_uart_rx,
    output logic        o_valid,
    input  logic        o_ready,
    output logic [31:0] o_data,
    output logic        o_frame_err,
    output logic        o_overflow
);

    localparam bit BIG     = (ENDIAN == "BIG");
    localparam int TMO_CYC = TIMEOUT_BITS * CLK_DIV;
    localparam int TMO_W   = (TMO_CYC > 1) ? $clog2(TMO_CYC + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

    logic                      byte_valid;
    logic [UART_DATA_BITS-1:0] byte_data;
    logic                      frame_err;
    logic                      idle;

    logic [1:0]       byte_cnt_q;
    logic [31:0]      stage_q;
    logic [31:0]      stage_d;
    logic [1:0]       lane;
    logic [TMO_W-1:0] tmo_q;
    logic             valid_q;
    logic [31:0]      data_q;
    logic             frame_err_q;
    logic             overflow_q;

    uart_rx_byte #(
        .CLK_DIV (CLK_DIV)
    ) u_byte (
        .clk          (clk),
        .rstn         (rstn),
        .rx_i         (i_uart_rx),
        .byte_valid_o (byte_valid),
        .byte_data_o  (byte_data),
        .frame_err_o  (frame_err),
        .idle_o       (idle)
    );

    assign lane = BIG ? (2'd3 - byte_cnt_q) : byte_cnt_q;

    always_comb begin
        stage_d = stage_q;
        stage_d[{lane, 3'b000} +: UART_DATA_BITS] = byte_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            byte_cnt_q  <= '0;
            stage_q     <= '0;
            tmo_q       <= '0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            frame_err_q <= frame_err;
            overflow_q  <= 1'b0;
            if (valid_q && o_ready) begin
                valid_q <= 1'b0;
            end
            if (byte_valid) begin
                stage_q    <= stage_d;
                byte_cnt_q <= byte_cnt_q + 2'd1;
                tmo_q      <= '0;
                // A completed word loads only if the output slot is free or being drained now.
                if (byte_cnt_q == 2'd3) begin
                    if (!valid_q || o_ready) begin
                        data_q  <= stage_d;
                        valid_q <= 1'b1;
                    end else begin
                        overflow_q <= 1'b1;
                    end
                end
            end else if (!idle || byte_cnt_q == 2'd0) begin
                tmo_q <= '0;
            end else if (TIMEOUT_BITS != 0) begin
                if (tmo_q == TMO_LAST) begin
                    byte_cnt_q <= '0;
                    tmo_q      <= '0;
                end else begin
                    tmo_q <= tmo_q + TMO_W'(1);
                end
            end
        end
    end

    assign o_valid     = valid_q;
    assign o_data      = data_q;
    assign o_frame_err = frame_err_q;
    assign o_overflow  = overflow_q;

endmodule
